multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the 64-bit RV core's shared datapath: one ALU, one unified memory port, one register-file write port. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the per-state datapath enables. Handshakes with memory via req/ready with a wait-state timeout. Halts on illegal opcode or bus timeout, and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the shared-datapath RV64 core.
// Steps FETCH/DECODE/EXEC/MEM/WB, guards memory waits, counts retires.
module multicycle_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [6:0]       opcode,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_write,
   output logic             mdr_write,
   output logic             alu_src,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic             pc_write,
   output logic             pc_src,
   output logic             halted,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] instret
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [6:0] OpR     = 7'b0110011;
   localparam logic [6:0] OpI     = 7'b0010011;
   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpJalr  = 7'b1100111;

   typedef enum logic [2:0] {
      Fetch  = 3'd0,
      Decode = 3'd1,
      Exec   = 3'd2,
      Mem    = 3'd3,
      Wb     = 3'd4,
      Halt   = 3'd5
   } state_t;

   state_t        state;
   logic [6:0]    opQ;
   logic [CW-1:0] waitCnt;
   logic          illegalQ;
   logic          busErrQ;
   logic          timeoutHit;
   logic          opLegal;
   logic          isR;
   logic          isI;
   logic          isLoad;
   logic          isStore;
   logic          isJalr;

   // Classify the latched opcode; drives EXEC/MEM/WB controls.
   always_comb begin
      isR     = (opQ == OpR);
      isI     = (opQ == OpI);
      isLoad  = (opQ == OpLoad);
      isStore = (opQ == OpStore);
      isJalr  = (opQ == OpJalr);
   end

   // Legality of the incoming opcode while in DECODE.
   always_comb begin
      opLegal = 1'b0;
      unique case (1'b1)
         (opcode == OpR):     opLegal = 1'b1;
         (opcode == OpI):     opLegal = 1'b1;
         (opcode == OpLoad):  opLegal = 1'b1;
         (opcode == OpStore): opLegal = 1'b1;
         (opcode == OpJalr):  opLegal = 1'b1;
         default:             opLegal = 1'b0;
      endcase
   end

   // Last allowed not-ready cycle of a request; TIMEOUT=0 never fires.
   always_comb begin
      timeoutHit = (TIMEOUT != 0) &&
                   (waitCnt == CW'(TIMEOUT - 1));
   end

   // State, latched opcode, wait counter, sticky flags, retire count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= Fetch;
         opQ      <= '0;
         waitCnt  <= '0;
         instret  <= '0;
         illegalQ <= 1'b0;
         busErrQ  <= 1'b0;
      end else begin
         unique case (state)
            Fetch: begin
               if (run) begin
                  if (mem_ready) begin
                     state   <= Decode;
                     waitCnt <= '0;
                  end else if (timeoutHit) begin
                     state   <= Halt;
                     busErrQ <= 1'b1;
                  end else begin
                     waitCnt <= waitCnt + CW'(1);
                  end
               end
            end
            Decode: begin
               opQ <= opcode;
               if (opLegal) begin
                  state <= Exec;
               end else begin
                  state    <= Halt;
                  illegalQ <= 1'b1;
               end
            end
            Exec: begin
               if (isLoad || isStore) begin
                  state   <= Mem;
                  waitCnt <= '0;
               end else begin
                  state <= Wb;
               end
            end
            Mem: begin
               if (mem_ready) begin
                  waitCnt <= '0;
                  if (isStore) begin
                     state   <= Fetch;
                     instret <= instret + CNT_W'(1);
                  end else begin
                     state <= Wb;
                  end
               end else if (timeoutHit) begin
                  state   <= Halt;
                  busErrQ <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + CW'(1);
               end
            end
            Wb: begin
               state   <= Fetch;
               waitCnt <= '0;
               instret <= instret + CNT_W'(1);
            end
            Halt: begin
               state <= Halt;
            end
            default: begin
               state <= Halt;
            end
         endcase
      end
   end

   // Per-state datapath enables, decoded from state and opQ.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_write  = 1'b0;
      mdr_write = 1'b0;
      alu_src   = 1'b0;
      alu_op    = 2'b11;
      reg_write = 1'b0;
      wb_sel    = 2'b00;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      halted    = 1'b0;
      if (state == Exec || state == Mem || state == Wb) begin
         alu_src = ~isR;
         unique case (1'b1)
            isR:     alu_op = 2'b10;
            isI:     alu_op = 2'b01;
            default: alu_op = 2'b00;
         endcase
      end
      unique case (state)
         Fetch: begin
            mem_req  = run;
            ir_write = run & mem_ready;
         end
         Mem: begin
            mem_req   = 1'b1;
            addr_sel  = 1'b1;
            mem_we    = isStore;
            mdr_write = mem_ready & isLoad;
            pc_write  = mem_ready & isStore;
         end
         Wb: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            pc_src    = isJalr;
            wb_sel    = isLoad ? 2'b01 :
                        isJalr ? 2'b10 : 2'b00;
         end
         Halt: begin
            halted = 1'b1;
         end
         default: begin
            halted = 1'b0;
         end
      endcase
   end

   assign illegal = illegalQ;
   assign bus_err = busErrQ;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl.
// TIMEOUT=4, CNT_W=4 so timeout and counter wrap are cheap to reach.
module tb_multicycle_ctrl;

   localparam logic [6:0] OpR     = 7'b0110011;
   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpJalr  = 7'b1100111;
   localparam logic [6:0] OpBad   = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [6:0] opcode = '0;
   logic       mem_ready = 1'b0;
   logic       mem_req;
   logic       mem_we;
   logic       addr_sel;
   logic       ir_write;
   logic       mdr_write;
   logic       alu_src;
   logic [1:0] alu_op;
   logic       reg_write;
   logic [1:0] wb_sel;
   logic       pc_write;
   logic       pc_src;
   logic       halted;
   logic       illegal;
   logic       bus_err;
   logic [3:0] instret;

   int nTests = 0;
   int nFail  = 0;

   multicycle_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .addr_sel(addr_sel), .ir_write(ir_write),
      .mdr_write(mdr_write), .alu_src(alu_src), .alu_op(alu_op),
      .reg_write(reg_write), .wb_sel(wb_sel), .pc_write(pc_write),
      .pc_src(pc_src), .halted(halted), .illegal(illegal),
      .bus_err(bus_err), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      run = 1'b0;
      mem_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = '0;
      #3;
      nTests++;
      if ({mem_req, ir_write, reg_write, pc_write, mem_we} !== 5'b0) begin
         nFail++;
         $display("FAIL reset_ctrl: got %b want 00000",
                  {mem_req, ir_write, reg_write, pc_write, mem_we});
      end
      nTests++;
      if ({halted, illegal, bus_err} !== 3'b000) begin
         nFail++;
         $display("FAIL reset_flags: got %b want 000",
                  {halted, illegal, bus_err});
      end
      nTests++;
      if (instret !== 4'd0) begin
         nFail++;
         $display("FAIL reset_instret: got %0d want 0", instret);
      end
      run = 1'b1;
      #1;
      nTests++;
      if (mem_req !== 1'b1) begin
         nFail++;
         $display("FAIL reset_memreq_run: got %b want 1", mem_req);
      end
      tick();
      rst = 1'b0;
      run = 1'b0;
   endtask

   task automatic test_rtype();
      run = 1'b1; mem_ready = 1'b1; opcode = OpR;
      #1;
      nTests++;
      if ({mem_req, ir_write, addr_sel} !== 3'b110) begin
         nFail++;
         $display("FAIL r_fetch: got %b want 110",
                  {mem_req, ir_write, addr_sel});
      end
      tick(); #1;
      nTests++;
      if ({mem_req, ir_write, halted} !== 3'b000) begin
         nFail++;
         $display("FAIL r_decode: got %b want 000",
                  {mem_req, ir_write, halted});
      end
      tick(); #1;
      nTests++;
      if ({alu_op, alu_src, reg_write} !== 4'b1000) begin
         nFail++;
         $display("FAIL r_exec: got %b want 1000",
                  {alu_op, alu_src, reg_write});
      end
      tick(); #1;
      nTests++;
      if ({reg_write, wb_sel, alu_op, pc_write, pc_src} !== 7'b1001010) begin
         nFail++;
         $display("FAIL r_wb: got %b want 1001010",
                  {reg_write, wb_sel, alu_op, pc_write, pc_src});
      end
      nTests++;
      if (instret !== 4'd0) begin
         nFail++;
         $display("FAIL r_instret_wb: got %0d want 0", instret);
      end
      tick();
      run = 1'b0;
      #1;
      nTests++;
      if (instret !== 4'd1) begin
         nFail++;
         $display("FAIL r_instret: got %0d want 1", instret);
      end
   endtask

   task automatic test_load();
      run = 1'b1; mem_ready = 1'b1; opcode = OpLoad;
      #1;
      nTests++;
      if (ir_write !== 1'b1) begin
         nFail++;
         $display("FAIL ld_fetch: got %b want 1", ir_write);
      end
      tick(); #1;
      tick(); #1;
      nTests++;
      if ({alu_op, alu_src} !== 3'b001) begin
         nFail++;
         $display("FAIL ld_exec: got %b want 001", {alu_op, alu_src});
      end
      tick();
      mem_ready = 1'b0;
      #1;
      nTests++;
      if ({mem_req, addr_sel, mem_we, mdr_write} !== 4'b1100) begin
         nFail++;
         $display("FAIL ld_mem1: got %b want 1100",
                  {mem_req, addr_sel, mem_we, mdr_write});
      end
      tick(); #1;
      nTests++;
      if ({mem_req, mdr_write} !== 2'b10) begin
         nFail++;
         $display("FAIL ld_mem2: got %b want 10", {mem_req, mdr_write});
      end
      tick();
      mem_ready = 1'b1;
      #1;
      nTests++;
      if ({mem_req, mdr_write, reg_write} !== 3'b110) begin
         nFail++;
         $display("FAIL ld_mem3: got %b want 110",
                  {mem_req, mdr_write, reg_write});
      end
      tick(); #1;
      nTests++;
      if ({reg_write, wb_sel, pc_write} !== 4'b1011) begin
         nFail++;
         $display("FAIL ld_wb: got %b want 1011",
                  {reg_write, wb_sel, pc_write});
      end
      tick();
      run = 1'b0;
      #1;
      nTests++;
      if (instret !== 4'd2) begin
         nFail++;
         $display("FAIL ld_instret: got %0d want 2", instret);
      end
   endtask

   task automatic test_store_jalr();
      run = 1'b1; mem_ready = 1'b1; opcode = OpStore;
      tick(); #1;
      tick(); #1;
      tick(); #1;
      nTests++;
      if ({mem_req, mem_we, addr_sel} !== 3'b111) begin
         nFail++;
         $display("FAIL st_mem: got %b want 111",
                  {mem_req, mem_we, addr_sel});
      end
      nTests++;
      if ({pc_write, pc_src, reg_write, mdr_write} !== 4'b1000) begin
         nFail++;
         $display("FAIL st_pc: got %b want 1000",
                  {pc_write, pc_src, reg_write, mdr_write});
      end
      tick();
      opcode = OpJalr;
      #1;
      nTests++;
      if ({mem_req, ir_write, addr_sel, mem_we} !== 4'b1100) begin
         nFail++;
         $display("FAIL st_refetch: got %b want 1100",
                  {mem_req, ir_write, addr_sel, mem_we});
      end
      nTests++;
      if (instret !== 4'd3) begin
         nFail++;
         $display("FAIL st_instret: got %0d want 3", instret);
      end
      tick(); #1;
      tick(); #1;
      nTests++;
      if ({alu_op, alu_src, mem_req} !== 4'b0010) begin
         nFail++;
         $display("FAIL jalr_exec: got %b want 0010",
                  {alu_op, alu_src, mem_req});
      end
      tick(); #1;
      nTests++;
      if ({wb_sel, pc_src, pc_write, reg_write} !== 5'b10111) begin
         nFail++;
         $display("FAIL jalr_wb: got %b want 10111",
                  {wb_sel, pc_src, pc_write, reg_write});
      end
      tick();
      run = 1'b0;
      #1;
      nTests++;
      if (instret !== 4'd4) begin
         nFail++;
         $display("FAIL jalr_instret: got %0d want 4", instret);
      end
   endtask

   task automatic test_illegal();
      run = 1'b1; mem_ready = 1'b1; opcode = OpBad;
      tick(); #1;
      tick(); #1;
      nTests++;
      if ({halted, illegal, bus_err, mem_req} !== 4'b1100) begin
         nFail++;
         $display("FAIL ill_halt: got %b want 1100",
                  {halted, illegal, bus_err, mem_req});
      end
      for (int i = 0; i < 10; i++) begin
         tick(); #1;
         nTests++;
         if ({mem_req, pc_write, reg_write, halted} !== 4'b0001) begin
            nFail++;
            $display("FAIL ill_hold%0d: got %b want 0001", i,
                     {mem_req, pc_write, reg_write, halted});
         end
      end
      nTests++;
      if (instret !== 4'd4) begin
         nFail++;
         $display("FAIL ill_instret: got %0d want 4", instret);
      end
      doReset();
      #1;
      nTests++;
      if ({halted, illegal, bus_err, instret} !== 7'b0) begin
         nFail++;
         $display("FAIL ill_rst: got %b want 0000000",
                  {halted, illegal, bus_err, instret});
      end
   endtask

   task automatic test_timeout();
      doReset();
      run = 1'b1; mem_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
      end
      nTests++;
      if ({mem_req, halted, bus_err} !== 3'b100) begin
         nFail++;
         $display("FAIL to_cycle4: got %b want 100",
                  {mem_req, halted, bus_err});
      end
      tick(); #1;
      nTests++;
      if ({mem_req, halted, bus_err, illegal} !== 4'b0110) begin
         nFail++;
         $display("FAIL to_halt: got %b want 0110",
                  {mem_req, halted, bus_err, illegal});
      end
      doReset();
      run = 1'b1; mem_ready = 1'b0; opcode = OpLoad;
      #1;
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
      end
      mem_ready = 1'b1;
      #1;
      nTests++;
      if ({ir_write, bus_err} !== 2'b10) begin
         nFail++;
         $display("FAIL to_late_ready: got %b want 10",
                  {ir_write, bus_err});
      end
      tick(); #1;
      nTests++;
      if ({mem_req, halted, bus_err} !== 3'b000) begin
         nFail++;
         $display("FAIL to_decode: got %b want 000",
                  {mem_req, halted, bus_err});
      end
      tick(); #1;
      tick();
      mem_ready = 1'b0;
      #1;
      nTests++;
      if ({mem_req, addr_sel} !== 2'b11) begin
         nFail++;
         $display("FAIL to_mid_mem: got %b want 11", {mem_req, addr_sel});
      end
      rst = 1'b1;
      #1;
      nTests++;
      if ({mem_req, addr_sel, mdr_write} !== 3'b100) begin
         nFail++;
         $display("FAIL rst_mid_mem: got %b want 100",
                  {mem_req, addr_sel, mdr_write});
      end
      run = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      nTests++;
      if ({mem_req, addr_sel, halted, bus_err, instret} !== 8'b0) begin
         nFail++;
         $display("FAIL rst_after_mem: got %b want 00000000",
                  {mem_req, addr_sel, halted, bus_err, instret});
      end
   endtask

   task automatic test_wrap();
      doReset();
      run = 1'b1; mem_ready = 1'b1; opcode = OpR;
      repeat (60) tick();
      #1;
      nTests++;
      if (instret !== 4'd15) begin
         nFail++;
         $display("FAIL wrap_15: got %0d want 15", instret);
      end
      repeat (4) tick();
      #1;
      nTests++;
      if (instret !== 4'd0) begin
         nFail++;
         $display("FAIL wrap_0: got %0d want 0", instret);
      end
      run = 1'b0;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_load();
      test_store_jalr();
      test_illegal();
      test_timeout();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
